// File: rtl/reg_file_pkg.sv
// Register file shared types and default geometry.
// Used by reg_file_2r1w and its read selectors.
package reg_file_pkg;

  localparam int RF_WIDTH  = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_ADDR_W = $clog2(RF_DEPTH);
  localparam int ZERO_ADDR = 0;

  typedef logic [RF_WIDTH-1:0]  word_t;
  typedef logic [RF_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/mux_nto1.sv
// Parametrised N:1 word selector over a flattened bus.
// Selects at or beyond N produce an all-zero word.
module mux_nto1
  import reg_file_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int N     = RF_DEPTH,
  parameter int SW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*WIDTH-1:0] I,
  input  logic [SW-1:0]      S,
  output logic [WIDTH-1:0]   O
);

  // One-hot compare across all entries; nothing matches when S >= N.
  always_comb begin
    O = '0;
    for (int i = 0; i < N; i++) begin
      if (S == SW'(i)) begin
        O = I[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Two registered read ports, one write port register file.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ZADDR   = ADDR_W'(ZERO_ADDR);
  localparam bit                ZR      = (ZERO_REG != 0);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH*WIDTH-1:0] flat;
  logic                   wvalid;
  logic [WIDTH-1:0]       mux_a;
  logic [WIDTH-1:0]       mux_b;
  logic [WIDTH-1:0]       sel_a;
  logic [WIDTH-1:0]       sel_b;

  // A write lands only on an in-range address that is not the hard zero.
  always_comb begin
    wvalid = we
      && ({1'b0, waddr} < DEPTH_X)
      && !(ZR && (waddr == ZADDR));
  end

  // Storage array: cleared by reset, one entry written per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wvalid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == ADDR_W'(i)) begin
          mem[i] <= wdata;
        end
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign flat[g*WIDTH +: WIDTH] = mem[g];
  end

  mux_nto1 #(
    .WIDTH (WIDTH),
    .N     (DEPTH),
    .SW    (ADDR_W)
  ) u_mux_a (
    .I (flat),
    .S (raddr_a),
    .O (mux_a)
  );

  mux_nto1 #(
    .WIDTH (WIDTH),
    .N     (DEPTH),
    .SW    (ADDR_W)
  ) u_mux_b (
    .I (flat),
    .S (raddr_b),
    .O (mux_b)
  );

  // Port A select: zero register mask, then optional write forwarding.
  always_comb begin
    sel_a = mux_a;
    if (ZR && (raddr_a == ZADDR)) begin
      sel_a = '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (wvalid && (raddr_a == waddr)) begin
      sel_a = wdata;
    end
`endif
  end

  // Port B select: zero register mask, then optional write forwarding.
  always_comb begin
    sel_b = mux_b;
    if (ZR && (raddr_b == ZADDR)) begin
      sel_b = '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (wvalid && (raddr_b == waddr)) begin
      sel_b = wdata;
    end
`endif
  end

  // Read registers: load on enable, hold otherwise, clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (re_a) begin
        rdata_a <= sel_a;
      end
      if (re_b) begin
        rdata_b <= sel_b;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w.
// Three instances (zero reg, no zero reg, depth 24) share one stimulus.
module tb_reg_file_2r1w;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re_a = 1'b0;
  logic [4:0]  raddr_a = '0;
  logic        re_b = 1'b0;
  logic [4:0]  raddr_b = '0;

  logic [31:0] oa [3];
  logic [31:0] ob [3];

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  reg_file_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(oa[0]),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(ob[0])
  );

  reg_file_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(oa[1]),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(ob[1])
  );

  reg_file_2r1w #(.WIDTH(32), .DEPTH(24), .ZERO_REG(1)) dut24 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(oa[2]),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(ob[2])
  );

  // Reference model: plain arrays per instance.
  int          dep [3] = '{32, 32, 24};
  bit          zr  [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] mm  [3][32];
  logic [31:0] ma  [3];
  logic [31:0] mb  [3];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 32; i++) mm[c][i] = '0;
      ma[c] = '0;
      mb[c] = '0;
    end
  endtask

  function automatic logic wvld(input int c, input logic w,
                                input logic [4:0] wa);
    return w && (int'(wa) < dep[c]) && !(zr[c] && wa == 5'd0);
  endfunction

  function automatic logic [31:0] msel(input int c, input logic [4:0] a,
                                       input logic w, input logic [4:0] wa,
                                       input logic [31:0] wd);
    if (int'(a) >= dep[c]) return '0;
    if (zr[c] && a == 5'd0) return '0;
    if (BYP && wvld(c, w, wa) && a == wa) return wd;
    return mm[c][a];
  endfunction

  task automatic check_all(input string nm);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("%s_a%0d", nm, c), oa[c], ma[c]);
      chk($sformatf("%s_b%0d", nm, c), ob[c], mb[c]);
    end
  endtask

  task automatic step(input string nm, input logic w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic rea,
                      input logic [4:0] ara, input logic reb,
                      input logic [4:0] arb);
    we = w; waddr = wa; wdata = wd;
    re_a = rea; raddr_a = ara;
    re_b = reb; raddr_b = arb;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      if (rea) ma[c] = msel(c, ara, w, wa, wd);
      if (reb) mb[c] = msel(c, arb, w, wa, wd);
    end
    for (int c = 0; c < 3; c++) begin
      if (wvld(c, w, wa)) mm[c][wa] = wd;
    end
    #1;
    check_all(nm);
  endtask

  typedef struct {
    logic        w;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rea;
    logic [4:0]  ara;
    logic        reb;
    logic [4:0]  arb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic        w;
    logic [4:0]  wa;
    logic [4:0]  ara;
    logic [4:0]  arb;

    tbl[0] = '{1'b1, 5'd3, 32'd4, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 32'd0};
    tbl[1] = '{1'b1, 5'd9, 32'd10, 1'b1, 5'd3, 1'b1, 5'd9,
               32'd4, BYP ? 32'd10 : 32'd0};
    tbl[2] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 1'b1, 5'd9, 32'd4, 32'd10};
    tbl[3] = '{1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b1, 5'd31,
               32'd0, 32'd0};
    tbl[4] = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd3, 32'd0, 32'd4};

    model_clear();
    #1 rst = 1'b1;
    #10;
    check_all("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].w, tbl[i].wa, tbl[i].wd,
           tbl[i].rea, tbl[i].ara, tbl[i].reb, tbl[i].arb);
      chk($sformatf("tbl%0d_ea", i), oa[0], tbl[i].ea);
      chk($sformatf("tbl%0d_eb", i), ob[0], tbl[i].eb);
    end

    for (int k = 1; k < 32; k++) begin
      step("wr", 1'b1, 5'(k), 32'(k + 1), 1'b0, 5'd0, 1'b0, 5'd0);
    end
    step("basic", 1'b0, 5'd0, 32'd0, 1'b1, 5'd25, 1'b1, 5'd31);
    chk("basic_a", oa[0], 32'd26);
    chk("basic_b", ob[0], 32'd32);
    chk("basic24_a", oa[2], 32'd0);

    step("zw", 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
    step("zr", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    chk("zero_a", oa[0], 32'd0);
    chk("zero_b", ob[0], 32'd0);
    chk("nozero_a", oa[1], 32'h12345678);

    step("c0", 1'b1, 5'd7, 32'hA, 1'b0, 5'd0, 1'b0, 5'd0);
    step("c1", 1'b1, 5'd7, 32'hB, 1'b1, 5'd7, 1'b0, 5'd0);
    chk("coll_a", oa[0], BYP ? 32'hB : 32'hA);
    step("c2", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0);
    chk("coll_next", oa[0], 32'hB);

    step("h0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0);
    chk("hold_rd", oa[0], 32'd4);
    step("h1", 1'b1, 5'd3, 32'h55, 1'b0, 5'd9, 1'b1, 5'd9);
    chk("hold_a1", oa[0], 32'd4);
    chk("hold_b1", ob[0], 32'd10);
    step("h2", 1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 1'b1, 5'd25);
    chk("hold_a2", oa[0], 32'd4);
    chk("hold_b2", ob[0], 32'd26);
    step("h3", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0);
    chk("hold_a3", oa[0], 32'h55);

    step("np0", 1'b1, 5'd30, 32'hFF, 1'b0, 5'd0, 1'b0, 5'd0);
    step("np1", 1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 1'b1, 5'd23);
    chk("np24_a", oa[2], 32'd0);
    chk("np24_b", ob[2], 32'd24);
    chk("np32_a", oa[0], 32'hFF);

    step("r0", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    step("r1", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd5);
    chk("rpre_a", oa[0], 32'hDEADBEEF);
    we = 1'b0; re_a = 1'b0; re_b = 1'b0;
    #3 rst = 1'b1;
    model_clear();
    #1;
    check_all("rasync");
    @(posedge clk);
    #1 rst = 1'b0;
    step("rpost", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd5);
    chk("rpost_a", oa[0], 32'd0);

    for (int n = 0; n < 300; n++) begin
      w   = ($urandom_range(9) < 6);
      wa  = 5'($urandom_range(31));
      ara = 5'($urandom_range(31));
      arb = 5'($urandom_range(31));
      if ($urandom_range(3) == 0) ara = wa;
      if ($urandom_range(3) == 0) arb = wa;
      step("rnd", w, wa, $urandom, ($urandom_range(3) != 0), ara,
           ($urandom_range(3) != 0), arb);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
